// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: FSM state encoding, decoder store-strobe patterns, load codes,
// access-size type and helpers that map a strobe/load code onto an access
// size and test an address for misalignment.
package lsu_pkg;

    // FSM state encoding (kept as plain constants for legacy tooling)
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // Store byte-strobe patterns from the decoder
    localparam logic [3:0] WSTRB_SB = 4'b0001;
    localparam logic [3:0] WSTRB_SH = 4'b0011;
    localparam logic [3:0] WSTRB_SW = 4'b1111;

    // Load size/sign codes from the decoder
    localparam logic [3:0] LD_LB  = 4'b0001;
    localparam logic [3:0] LD_LH  = 4'b0011;
    localparam logic [3:0] LD_LW  = 4'b1111;
    localparam logic [3:0] LD_LBU = 4'b1001;
    localparam logic [3:0] LD_LHU = 4'b1011;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    // Unknown strobe patterns are treated as a full word.
    function automatic lsu_size_t store_size(input logic [3:0] wstrb);
        lsu_size_t sz;
        case (wstrb)
            WSTRB_SB: sz = SZ_BYTE;
            WSTRB_SH: sz = SZ_HALF;
            default:  sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Unknown load codes behave as lw.
    function automatic lsu_size_t load_size(input logic [3:0] code);
        lsu_size_t sz;
        case (code)
            LD_LB, LD_LBU: sz = SZ_BYTE;
            LD_LH, LD_LHU: sz = SZ_HALF;
            default:       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] addr_lo);
        logic mis;
        case (sz)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Request side : addr_lo, is_store, is_load, wstrb, wdata, load_code
//                -> st_be (shifted strobes), st_wdata (lane-replicated),
//                   misaligned (size vs. address check).
// Response side: rd_addr_lo, rd_load_code, rdata -> ld_data (shifted and
//                sign/zero-extended load result).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic        is_load,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic [3:0]  load_code,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic        misaligned,
    input  logic [1:0]  rd_addr_lo,
    input  logic [3:0]  rd_load_code,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift_s;

    // Store byte enables and replicated write data
    always_comb begin
        st_be = wstrb << addr_lo;
        case (store_size(wstrb))
            SZ_BYTE: st_wdata = {4{wdata[7:0]}};
            SZ_HALF: st_wdata = {2{wdata[15:0]}};
            default: st_wdata = wdata;
        endcase
    end

    // Misalignment check; a store wins when both read and write are set
    always_comb begin
        if (is_store) begin
            misaligned = is_misaligned(store_size(wstrb), addr_lo);
        end else if (is_load) begin
            misaligned = is_misaligned(load_size(load_code), addr_lo);
        end else begin
            misaligned = 1'b0;
        end
    end

    // Load extract: move the addressed lane to bit 0, then extend
    always_comb begin
        ld_shift_s = rdata >> {rd_addr_lo, 3'b000};
        case (rd_load_code)
            LD_LB:   ld_data = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
            LD_LBU:  ld_data = {24'h000000, ld_shift_s[7:0]};
            LD_LH:   ld_data = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
            LD_LHU:  ld_data = {16'h0000, ld_shift_s[15:0]};
            default: ld_data = ld_shift_s;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit.
// Accepts one operation at a time from the pipeline (req_valid_i/req_ready_o),
// runs a request/grant/rvalid transaction on the data-memory port, and
// returns exactly one response (rsp_valid_o, rdata_o, err_o) per request.
// Ports:
//   pipeline side : req_valid_i, req_ready_o, mem_write_i, mem_read_i, addr_i,
//                   wdata_i, wstrb_i, wstrb_load_i, busy_o
//   response      : rsp_valid_o, rdata_o, err_o
//   memory port   : dmem_req_o, dmem_gnt_i, dmem_we_o, dmem_addr_o, dmem_be_o,
//                   dmem_wdata_o, dmem_rvalid_i, dmem_rdata_i
// Misaligned and no-op requests skip the bus and respond the next cycle.
// A request stuck in REQ/WAIT_R for TIMEOUT_CYCLES cycles is abandoned
// with err_o=1. All outputs are registered.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              mem_write_i,
    input  logic              mem_read_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic [3:0]        wstrb_load_i,
    output logic              busy_o,
    output logic              rsp_valid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              dmem_req_o,
    input  logic              dmem_gnt_i,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i
);

    localparam int unsigned      CNT_W        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       addr_lo_r;
    logic [3:0]       load_code_r;

    logic             accept_s;
    logic             is_store_s;
    logic             is_load_s;
    logic             misaligned_s;
    logic             go_bus_s;
    logic             timeout_s;
    logic [3:0]       st_be_s;
    logic [31:0]      st_wdata_s;
    logic [31:0]      ld_data_s;

    assign accept_s   = req_valid_i & req_ready_o;
    assign is_store_s = mem_write_i;
    assign is_load_s  = mem_read_i & ~mem_write_i;
    assign go_bus_s   = (is_store_s | is_load_s) & ~misaligned_s;
    assign timeout_s  = (cnt_r == TIMEOUT_LAST);

    lsu_align u_align (
        .addr_lo      (addr_i[1:0]),
        .is_store     (is_store_s),
        .is_load      (is_load_s),
        .wstrb        (wstrb_i),
        .wdata        (wdata_i),
        .load_code    (wstrb_load_i),
        .st_be        (st_be_s),
        .st_wdata     (st_wdata_s),
        .misaligned   (misaligned_s),
        .rd_addr_lo   (addr_lo_r),
        .rd_load_code (load_code_r),
        .rdata        (dmem_rdata_i),
        .ld_data      (ld_data_s)
    );

    // Next-state logic; grant/rvalid take priority over the timeout
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = go_bus_s ? S_REQ : S_RESP;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (dmem_gnt_i) begin
                    state_next_s = dmem_we_o ? S_RESP : S_WAIT_R;
                end else if (timeout_s) begin
                    state_next_s = S_RESP;
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_WAIT_R: begin
                if (dmem_rvalid_i || timeout_s) begin
                    state_next_s = S_RESP;
                end else begin
                    state_next_s = S_WAIT_R;
                end
            end
            S_RESP:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, timeout counter, request capture and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= S_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            addr_lo_r    <= 2'b00;
            load_code_r  <= 4'b0000;
            req_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rdata_o      <= 32'h0000_0000;
            err_o        <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= {ADDR_W{1'b0}};
            dmem_be_o    <= 4'b0000;
            dmem_wdata_o <= 32'h0000_0000;
        end else begin
            state_r     <= state_next_s;
            req_ready_o <= (state_next_s == S_IDLE);
            busy_o      <= (state_next_s != S_IDLE);
            rsp_valid_o <= (state_next_s == S_RESP);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        cnt_r       <= {CNT_W{1'b0}};
                        addr_lo_r   <= addr_i[1:0];
                        load_code_r <= wstrb_load_i;
                        rdata_o     <= 32'h0000_0000;
                        err_o       <= misaligned_s;
                        if (go_bus_s) begin
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= is_store_s;
                            dmem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                            dmem_be_o    <= is_store_s ? st_be_s : 4'b1111;
                            dmem_wdata_o <= is_store_s ? st_wdata_s : 32'h0000_0000;
                        end
                    end
                end
                S_REQ: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    // Bus outputs stay stable until grant, then drop
                    if (dmem_gnt_i || timeout_s) begin
                        dmem_req_o   <= 1'b0;
                        dmem_we_o    <= 1'b0;
                        dmem_addr_o  <= {ADDR_W{1'b0}};
                        dmem_be_o    <= 4'b0000;
                        dmem_wdata_o <= 32'h0000_0000;
                    end
                    if (!dmem_gnt_i && timeout_s) begin
                        err_o <= 1'b1;
                    end
                end
                S_WAIT_R: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (dmem_rvalid_i) begin
                        rdata_o <= ld_data_s;
                    end else if (timeout_s) begin
                        err_o <= 1'b1;
                    end
                end
                S_RESP: begin
                    rdata_o <= 32'h0000_0000;
                    err_o   <= 1'b0;
                end
                default: begin
                    rdata_o <= 32'h0000_0000;
                    err_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the control decoder.
- Consumes the decoder's mem_write, load select, store byte-strobe pattern and load-size/sign code, plus the ALU-computed address and rs2 data.
- Runs a request/grant/rvalid transaction on the data-memory port, aligns and sign/zero-extends load data, and stalls the pipeline while busy.
- Returns one response per accepted request.

Parameters:
- TIMEOUT_CYCLES, 16, cycles spent waiting in REQ or WAIT_R before the access is abandoned with err_o=1.
- ADDR_W, 32, address width.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  pipeline presents a memory operation.
- req_ready_o  out  1  high only in IDLE; request accepted when req_valid_i & req_ready_o.
- mem_write_i  in  1  store (decoder mem_write).
- mem_read_i  in  1  load (decoder Res_src==01).
- addr_i  in  ADDR_W  byte address from ALU.
- wdata_i  in  32  rs2 value.
- wstrb_i  in  4  store pattern: 0001 sb, 0011 sh, 1111 sw.
- wstrb_load_i  in  4  load code: 0001 lb, 0011 lh, 1111 lw, 1001 lbu, 1011 lhu; any other value = lw.
- busy_o  out  1  stall to pipeline; high from acceptance until the cycle rsp_valid_o is high.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load data; 0 for stores and errors.
- err_o  out  1  valid with rsp_valid_o; misalignment or timeout.
- dmem_req_o  out  1  bus request.
- dmem_gnt_i  in  1  bus grant.
- dmem_we_o  out  1  write enable.
- dmem_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated write data.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  32  read word.

Behaviour:
- Reset state: FSM IDLE; req_ready_o=1; all other outputs 0; timeout counter 0.
- Reset mid-operation: the same reset values take effect in the cycle after reset_i is sampled high. Any rvalid arriving later in IDLE is ignored.
- States and transitions:
  - IDLE -> REQ: on acceptance. Register addr, data, be, we, load code. Counter cleared.
  - IDLE -> RESP: on acceptance if misaligned, with err=1 and no bus activity.
  - IDLE -> RESP: on acceptance if neither mem_read_i nor mem_write_i, with err=0 and rdata=0.
  - REQ: dmem_req_o=1 with stable addr/be/we/wdata until dmem_gnt_i. Grant on a store -> RESP. Grant on a load -> WAIT_R.
  - WAIT_R: on dmem_rvalid_i, capture the extended data -> RESP. Earliest rvalid is the cycle after grant; rvalid in the grant cycle is ignored.
  - RESP: rsp_valid_o=1 for exactly one cycle, then IDLE.
- Timeout: counter increments each cycle in REQ or WAIT_R. When it reaches TIMEOUT_CYCLES-1 with no gnt/rvalid -> RESP with err=1 and dmem_req_o dropped.
- Latency: acceptance cycle N -> dmem_req_o at N+1.
  - Store with immediate grant: rsp at N+2.
  - Load with grant at N+1 and rvalid at N+2: rsp at N+3.
- Both mem_write_i and mem_read_i high: treated as a store.
- Alignment:
  - Half: misaligned if addr[0]=1.
  - Word: misaligned if addr[1:0]!=0.
  - Byte: never misaligned.
- Store lanes:
  - be = wstrb_i << addr[1:0].
  - wdata replicated: sb {4{wdata[7:0]}}, sh {2{wdata[15:0]}}, sw as-is.
- Load extract:
  - Shift: word = dmem_rdata_i >> (8*addr[1:0]).
  - Extension: lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
  - Load be = 1111.
- Back-to-back: a new request is accepted in the cycle after RESP (IDLE); there is no overlap.

Decomposition:
- Shared package lsu_pkg:
  - FSM state enum (IDLE, REQ, WAIT_R, RESP).
  - Localparams for wstrb patterns (SB/SH/SW).
  - Localparams for load codes (LB/LH/LW/LBU/LHU).
- One combinational sub-module, lsu_align: store lane/be generation, misalignment check, load extract/extend. The FSM and timeout counter stay in the top.

Test Plan:
- sw addr=0x104, wdata=0xDEADBEEF, gnt same cycle -> dmem_be_o=1111, dmem_addr_o=0x104, dmem_wdata_o=0xDEADBEEF; rsp_valid at N+2, err=0.
- sb addr=0x203, wdata=0x000000A5 -> dmem_be_o=1000, dmem_addr_o=0x200, dmem_wdata_o=0xA5A5A5A5.
- lb and lbu at addr=0x302, rdata=0x12F45678 -> lb rdata_o=0xFFFFFFF4; lbu rdata_o=0x000000F4; rsp 1 cycle after rvalid.
- lh addr=0x101 -> no dmem_req_o; rsp_valid at N+1, err_o=1, rdata_o=0.
- lw with gnt withheld and TIMEOUT_CYCLES=4 -> dmem_req_o high 4 cycles, then dropped; rsp err_o=1.
- reset_i asserted during WAIT_R, then rvalid arrives -> FSM IDLE, rsp_valid_o stays 0, req_ready_o=1.
